// File: rtl/pri_enc_pkg.sv
// Shared helpers for the registered priority encoder.
// Width helper, priority-index search and the idle code constant.
package pri_enc_pkg;

    localparam int MAX_N = 64;
    localparam int MAX_W = 6;

    // Idle / disabled code: all ones, truncated to W by the user.
    localparam logic [MAX_W-1:0] IDLE_CODE = '1;

    function automatic int safe_clog2(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Index of the highest-priority set bit of vec[n-1:0]. Priority runs
    // ptr, ptr-1, ..., 0, n-1, ..., ptr+1. Candidates are visited from
    // lowest to highest priority so the last hit wins. ptr = n-1 gives
    // plain fixed priority (highest index first).
    function automatic int pri_idx(input logic [MAX_N-1:0] vec,
                                   input int n,
                                   input int ptr);
        int best;
        int c;
        best = 0;
        for (int k = 0; k < MAX_N; k++) begin
            if (k < n) begin
                c = (ptr + 1 + k) % n;
                if (vec[c]) best = c;
            end
        end
        return best;
    endfunction

endpackage

// File: rtl/pri_enc_comb.sv
// Combinational N-to-W priority encoder with a rotate (pointer) input.
// ptr names the highest-priority line; tie it to N-1 for fixed priority.
module pri_enc_comb
    import pri_enc_pkg::*;
#(
    parameter  int N = 8,
    localparam int W = safe_clog2(N)
) (
    input  logic [N-1:0] vec,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] idx,
    output logic         any
);

    // Search for the winning index and flag whether anything is set.
    always_comb begin
        idx = W'(pri_idx(MAX_N'(vec), N, int'(ptr)));
        any = |vec;
    end

endmodule

// File: rtl/pri_encoder_irq.sv
// Registered sticky priority encoder with valid/ack retire and cascade enable.
// Optional macro PRI_ENC_RR_EN: rotating priority pointer, serviced line
// becomes lowest priority. Undefined: fixed priority, highest index first.
module pri_encoder_irq
    import pri_enc_pkg::*;
#(
    parameter  int N = 8,
    localparam int W = safe_clog2(N)
) (
    input  logic         iClk,
    input  logic         iRst,
    input  logic [N-1:0] iReq,
    input  logic         iEI,
    input  logic         iAck,
    output logic [W-1:0] oData,
    output logic         oValid,
    output logic         oEO,
    output logic [N-1:0] oPending
);

    localparam logic [W-1:0] IDLE = IDLE_CODE[W-1:0];
    localparam logic [W-1:0] PTR_RST = W'(N - 1);

    logic [N-1:0] pending_q, pending_d;
    logic [W-1:0] data_q, data_d;
    logic         valid_q, valid_d;
    logic         eo_q, eo_d;
    logic [W-1:0] ptr_d;

    logic [N-1:0] req;
    logic [N-1:0] clr;
    logic [W-1:0] cur_idx;
    logic         acc;
    logic [W-1:0] enc_idx;
    logic         enc_any;

    // Accept decode and sticky pending update; a same-cycle re-request
    // survives the clear of its own bit.
    always_comb begin
        req     = ~iReq;
        cur_idx = ~data_q;
        acc     = iAck & valid_q & ~iEI;
        clr     = acc ? (N'(1) << cur_idx) : '0;
        if (iEI) pending_d = pending_q;
        else     pending_d = (pending_q & ~clr) | req;
    end

`ifdef PRI_ENC_RR_EN
    logic [W-1:0] ptr_q;

    // Pointer moves to one below the serviced index; the encoder sees the
    // updated pointer so the next code already reflects the rotation.
    always_comb begin
        ptr_d = ptr_q;
        if (acc) ptr_d = (cur_idx == '0) ? PTR_RST : cur_idx - 1'b1;
    end

    // Pointer register.
    always_ff @(posedge iClk) begin
        if (iRst) ptr_q <= PTR_RST;
        else      ptr_q <= ptr_d;
    end
`else
    assign ptr_d = PTR_RST;
`endif

    pri_enc_comb #(.N(N)) u_enc (
        .vec (pending_d),
        .ptr (ptr_d),
        .idx (enc_idx),
        .any (enc_any)
    );

    // Output stage: clear on disable, load when idle or accepted, else hold.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        eo_d    = ~iEI & ~enc_any;
        if (iEI) begin
            valid_d = 1'b0;
            data_d  = IDLE;
        end else if (!valid_q || acc) begin
            valid_d = enc_any;
            data_d  = enc_any ? ~enc_idx : IDLE;
        end
    end

    // State registers with synchronous reset dominating all inputs.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            pending_q <= '0;
            valid_q   <= 1'b0;
            data_q    <= IDLE;
            eo_q      <= 1'b0;
        end else begin
            pending_q <= pending_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            eo_q      <= eo_d;
        end
    end

    assign oData    = data_q;
    assign oValid   = valid_q;
    assign oEO      = eo_q;
    assign oPending = pending_q;

endmodule

// File: tb/tb_pri_encoder_irq.sv
// Directed self-checking bench for pri_encoder_irq (N = 8).
module tb_pri_encoder_irq;

    logic       iClk = 1'b0;
    logic       iRst = 1'b1;
    logic [7:0] iReq = 8'hFF;
    logic       iEI  = 1'b0;
    logic       iAck = 1'b0;
    logic [2:0] oData;
    logic       oValid;
    logic       oEO;
    logic [7:0] oPending;

    int checks = 0;
    int passes = 0;

    pri_encoder_irq #(.N(8)) dut (
        .iClk     (iClk),
        .iRst     (iRst),
        .iReq     (iReq),
        .iEI      (iEI),
        .iAck     (iAck),
        .oData    (oData),
        .oValid   (oValid),
        .oEO      (oEO),
        .oPending (oPending)
    );

    always #5 iClk = ~iClk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic do_reset();
        iRst = 1'b1; iReq = 8'hFF; iEI = 1'b0; iAck = 1'b0;
        tick();
        iRst = 1'b0;
    endtask

    task automatic test_reset();
        iRst = 1'b1; iReq = 8'h00; iEI = 1'b0; iAck = 1'b1;
        tick();
        checks++; if (oValid !== 1'b0) $display("FAIL rst_valid got %b want 0", oValid); else passes++;
        checks++; if (oData !== 3'b111) $display("FAIL rst_data got %b want 111", oData); else passes++;
        checks++; if (oEO !== 1'b0) $display("FAIL rst_eo got %b want 0", oEO); else passes++;
        checks++; if (oPending !== 8'h00) $display("FAIL rst_pending got %h want 00", oPending); else passes++;
        iRst = 1'b0; iReq = 8'hFF; iAck = 1'b1;
        tick();
        checks++; if (oValid !== 1'b0) $display("FAIL idle_valid got %b want 0", oValid); else passes++;
        checks++; if (oData !== 3'b111) $display("FAIL idle_data got %b want 111", oData); else passes++;
        checks++; if (oEO !== 1'b1) $display("FAIL idle_eo got %b want 1", oEO); else passes++;
        checks++; if (oPending !== 8'h00) $display("FAIL idle_pending got %h want 00", oPending); else passes++;
        iAck = 1'b0;
    endtask

    task automatic test_two_req();
        iReq = 8'hDB;
        tick();
        checks++; if (oData !== 3'b010) $display("FAIL two_first got %b want 010", oData); else passes++;
        checks++; if (oValid !== 1'b1) $display("FAIL two_valid got %b want 1", oValid); else passes++;
        checks++; if (oPending !== 8'h24) $display("FAIL two_pending got %h want 24", oPending); else passes++;
        iReq = 8'hFF;
        tick();
        checks++; if (oData !== 3'b010) $display("FAIL two_hold got %b want 010", oData); else passes++;
        iAck = 1'b1;
        tick();
        checks++; if (oData !== 3'b101) $display("FAIL two_second got %b want 101", oData); else passes++;
        checks++; if (oPending !== 8'h04) $display("FAIL two_pending2 got %h want 04", oPending); else passes++;
        tick();
        checks++; if (oValid !== 1'b0) $display("FAIL two_done_valid got %b want 0", oValid); else passes++;
        checks++; if (oEO !== 1'b1) $display("FAIL two_done_eo got %b want 1", oEO); else passes++;
        checks++; if (oData !== 3'b111) $display("FAIL two_done_data got %b want 111", oData); else passes++;
        iAck = 1'b0;
    endtask

    task automatic test_preempt();
        iReq = 8'hDF;
        tick();
        checks++; if (oData !== 3'b010) $display("FAIL pre_first got %b want 010", oData); else passes++;
        iReq = 8'h7F;
        tick();
        checks++; if (oData !== 3'b010) $display("FAIL pre_hold got %b want 010", oData); else passes++;
        checks++; if (oPending !== 8'hA0) $display("FAIL pre_pending got %h want a0", oPending); else passes++;
        iReq = 8'hFF; iAck = 1'b1;
        tick();
        checks++; if (oData !== 3'b000) $display("FAIL pre_next got %b want 000", oData); else passes++;
        checks++; if (oPending !== 8'h80) $display("FAIL pre_pending2 got %h want 80", oPending); else passes++;
        tick();
        checks++; if (oValid !== 1'b0) $display("FAIL pre_done got %b want 0", oValid); else passes++;
        iAck = 1'b0;
    endtask

    task automatic test_disable();
        do_reset();
        iReq = 8'h7E;
        tick();
        checks++; if (oData !== 3'b000) $display("FAIL dis_first got %b want 000", oData); else passes++;
        checks++; if (oPending !== 8'h81) $display("FAIL dis_pending got %h want 81", oPending); else passes++;
        iReq = 8'hFF; iEI = 1'b1;
        tick();
        checks++; if (oValid !== 1'b0) $display("FAIL dis_valid got %b want 0", oValid); else passes++;
        checks++; if (oData !== 3'b111) $display("FAIL dis_data got %b want 111", oData); else passes++;
        checks++; if (oEO !== 1'b0) $display("FAIL dis_eo got %b want 0", oEO); else passes++;
        checks++; if (oPending !== 8'h81) $display("FAIL dis_keep got %h want 81", oPending); else passes++;
        iAck = 1'b1; iReq = 8'hEF;
        tick();
        checks++; if (oPending !== 8'h81) $display("FAIL dis_block got %h want 81", oPending); else passes++;
        iAck = 1'b0; iEI = 1'b0; iReq = 8'hFF;
        tick();
        checks++; if (oData !== 3'b000) $display("FAIL dis_resume got %b want 000", oData); else passes++;
        checks++; if (oValid !== 1'b1) $display("FAIL dis_resume_v got %b want 1", oValid); else passes++;
        iAck = 1'b1;
        tick();
        checks++; if (oData !== 3'b111 || oValid !== 1'b1) $display("FAIL dis_idx0 got %b/%b want 111/1", oData, oValid); else passes++;
        tick();
        checks++; if (oValid !== 1'b0 || oEO !== 1'b1) $display("FAIL dis_drain got %b/%b want 0/1", oValid, oEO); else passes++;
        iAck = 1'b0;
    endtask

    task automatic test_level_hold();
        iReq = 8'hF7; iAck = 1'b1;
        tick();
        checks++; if (oData !== 3'b100) $display("FAIL lvl_first got %b want 100", oData); else passes++;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (oData !== 3'b100 || oValid !== 1'b1) $display("FAIL lvl_cyc%0d got %b/%b want 100/1", i, oData, oValid); else passes++;
            checks++; if (oPending !== 8'h08) $display("FAIL lvl_pend%0d got %h want 08", i, oPending); else passes++;
        end
        iRst = 1'b1;
        tick();
        checks++; if (oValid !== 1'b0 || oData !== 3'b111) $display("FAIL lvl_rst got %b/%b want 0/111", oValid, oData); else passes++;
        checks++; if (oEO !== 1'b0 || oPending !== 8'h00) $display("FAIL lvl_rst2 got %b/%h want 0/00", oEO, oPending); else passes++;
        iRst = 1'b0; iReq = 8'hFF; iAck = 1'b0;
        tick();
        checks++; if (oEO !== 1'b1) $display("FAIL lvl_eo got %b want 1", oEO); else passes++;
    endtask

    task automatic test_rr();
        logic [2:0] exp;
        iReq = 8'h3F; iAck = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
`ifdef PRI_ENC_RR_EN
            exp = (i % 2 == 1) ? 3'b001 : 3'b000;
`else
            exp = 3'b000;
`endif
            checks++; if (oData !== exp || oValid !== 1'b1) $display("FAIL rr_cyc%0d got %b/%b want %b/1", i, oData, oValid, exp); else passes++;
        end
        iReq = 8'hFF;
        tick(); tick(); tick();
        checks++; if (oValid !== 1'b0 || oPending !== 8'h00) $display("FAIL rr_drain got %b/%h want 0/00", oValid, oPending); else passes++;
        iAck = 1'b0;
    endtask

    initial begin
        test_reset();
        test_two_req();
        test_preempt();
        test_disable();
        test_level_hold();
        test_rr();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
